// File: rtl/fa_pkg.sv
// Shared types and constants for the frame-access fetchers.
// Coordinates are pixel-based; block indices are 8-bit.
// The block tag travels with each read so rows leave the FIFO self-describing.
package fa_pkg;

  localparam int BLK       = 8;
  localparam int PIX_BITS  = 8;
  localparam int COORD_W   = 11;
  localparam int DIM_W     = 12;
  localparam int BLK_IDX_W = 8;
  localparam int ROW_W     = 3;
  localparam int WORD_W    = BLK * PIX_BITS;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [ROW_W-1:0]     row;
    logic [BLK_IDX_W-1:0] bx;
    logic [BLK_IDX_W-1:0] by;
    logic                 last;
  } blk_tag_t;

  // Pixel coordinate of a block index plus row offset (blocks are 8 pixels on a side).
  function automatic logic [COORD_W-1:0] blk_to_pix(input logic [BLK_IDX_W-1:0] idx,
                                                    input logic [ROW_W-1:0]     row);
    return {idx, row};
  endfunction

endpackage

// File: rtl/block_fetch_if.sv
// Frame-buffer read port plus block-row output stream of the block fetcher.
// master = fetcher side, slave = frame buffer / encoder side.
// Read data returns exactly one cycle after rd_en; blk_* is valid/ready.
interface block_fetch_if #(
  parameter int MEM_WIDTH = fa_pkg::WORD_W
);
  import fa_pkg::*;

  logic                 rd_en;
  logic [COORD_W-1:0]   rd_x;
  logic [COORD_W-1:0]   rd_y;
  logic                 rd_valid;
  logic [MEM_WIDTH-1:0] rd_data;

  logic                 blk_valid;
  logic                 blk_ready;
  logic [MEM_WIDTH-1:0] blk_data;
  logic [ROW_W-1:0]     blk_row;
  logic [BLK_IDX_W-1:0] blk_bx;
  logic [BLK_IDX_W-1:0] blk_by;
  logic                 blk_last;

  modport master (
    output rd_en, rd_x, rd_y,
    input  rd_valid, rd_data,
    output blk_valid, blk_data, blk_row, blk_bx, blk_by, blk_last,
    input  blk_ready
  );

  modport slave (
    input  rd_en, rd_x, rd_y,
    output rd_valid, rd_data,
    input  blk_valid, blk_data, blk_row, blk_bx, blk_by, blk_last,
    output blk_ready
  );

endinterface

// File: rtl/skid_fifo.sv
// Generic synchronous FIFO with occupancy count; head is presented combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full are dropped unless a pop frees a slot the same cycle.
module skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       pop_valid,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_valid = (count != '0);
  assign pop_data  = mem[rd_ptr];
  assign do_pop    = pop && pop_valid;
  assign do_push   = push && ((count < CNT_W'(DEPTH)) || do_pop);

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/block_fetch.sv
// Walks a stored frame in 8x8 blocks (block-raster), reading 8 rows per block.
// Latency: start -> first read next cycle, first row valid two cycles after that read issues.
// Backpressure: reads issue only while FIFO occupancy plus in-flight read is below FIFO_DEPTH.
module block_fetch
  import fa_pkg::*;
#(
  parameter int MEM_WIDTH  = WORD_W,
  parameter int BLK        = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             setup_frame,
  input  logic [DIM_W-1:0] width_in,
  input  logic [DIM_W-1:0] height_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  block_fetch_if.master    bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam int TAG_W = $bits(blk_tag_t);
  localparam int WB_W  = DIM_W - 3;
  localparam int FW    = TAG_W + MEM_WIDTH;

  fetch_state_t         state_q, state_d;
  logic [WB_W-1:0]      w_blks, h_blks;
  logic [ROW_W-1:0]     row_q;
  logic [BLK_IDX_W-1:0] bx_q, by_q;
  logic                 inflight_q;
  blk_tag_t             tag_q;
  logic                 done_q, done_d;
  logic                 issue;
  logic [CNT_W-1:0]     fifo_count, cnt_nxt;
  logic                 push, pop, head_vld;
  logic [FW-1:0]        head_word;
  blk_tag_t             head_tag;
  logic                 row_end, bx_end, by_end, last_read;
  logic                 credit_ok, dims_zero;
  logic                 unused_dim_lsbs;

  // Dimensions are whole blocks; the sub-block remainder is meaningless here.
  assign unused_dim_lsbs = ^{width_in[2:0], height_in[2:0]};

  assign row_end   = (row_q == ROW_W'(BLK - 1));
  assign bx_end    = (WB_W'(bx_q) == (w_blks - 1'b1));
  assign by_end    = (WB_W'(by_q) == (h_blks - 1'b1));
  assign last_read = row_end && bx_end && by_end;
  assign dims_zero = (w_blks == '0) || (h_blks == '0);
  // The in-flight read already owns a FIFO slot, so the FIFO can never overflow.
  assign credit_ok = (OCC_W'(fifo_count) + OCC_W'(inflight_q)) < OCC_W'(FIFO_DEPTH);

  // Data without an outstanding read is a protocol error and is dropped.
  assign push = bus.rd_valid && inflight_q;
  assign pop  = head_vld && bus.blk_ready;

  assign busy        = (state_q != FETCH_IDLE);
  assign done        = done_q;
  assign bus.rd_en   = issue;
  assign bus.rd_x    = blk_to_pix(bx_q, '0);
  assign bus.rd_y    = blk_to_pix(by_q, row_q);

  assign head_tag      = blk_tag_t'(head_word[MEM_WIDTH +: TAG_W]);
  assign bus.blk_valid = head_vld;
  assign bus.blk_data  = head_word[MEM_WIDTH-1:0];
  assign bus.blk_row   = head_tag.row;
  assign bus.blk_bx    = head_tag.bx;
  assign bus.blk_by    = head_tag.by;
  assign bus.blk_last  = head_tag.last;

  // Next state, read issue and done pulse; drain ends when the FIFO empties at this edge.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    cnt_nxt = fifo_count;
    if (push && !pop)      cnt_nxt = fifo_count + 1'b1;
    else if (pop && !push) cnt_nxt = fifo_count - 1'b1;
    unique case (state_q)
      FETCH_IDLE: begin
        if (start) begin
          if (dims_zero) done_d  = 1'b1;
          else           state_d = FETCH_RUN;
        end
      end
      FETCH_RUN: begin
        issue = credit_ok;
        if (credit_ok && last_read) state_d = FETCH_DRAIN;
      end
      FETCH_DRAIN: begin
        // No reads issue here, so an empty FIFO after this edge also means nothing in flight.
        if (cnt_nxt == '0) begin
          state_d = FETCH_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Frame dimensions in blocks, accepted only while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_blks <= '0;
      h_blks <= '0;
    end else if (setup_frame && state_q == FETCH_IDLE) begin
      w_blks <= width_in[DIM_W-1:3];
      h_blks <= height_in[DIM_W-1:3];
    end
  end

  // Read position: row fastest, then block column, then block row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      bx_q  <= '0;
      by_q  <= '0;
    end else if (state_q == FETCH_IDLE && start) begin
      row_q <= '0;
      bx_q  <= '0;
      by_q  <= '0;
    end else if (issue) begin
      if (row_end) begin
        row_q <= '0;
        if (bx_end) begin
          bx_q <= '0;
          by_q <= by_q + 1'b1;
        end else begin
          bx_q <= bx_q + 1'b1;
        end
      end else begin
        row_q <= row_q + 1'b1;
      end
    end
  end

  // Tag of the single outstanding read; data is due exactly one cycle after issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) tag_q <= '{row: row_q, bx: bx_q, by: by_q, last: last_read};
    end
  end

  skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data ({tag_q, bus.rd_data}),
    .pop       (pop),
    .pop_valid (head_vld),
    .pop_data  (head_word),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_block_fetch.sv
// Scoreboard bench for block_fetch with a one-cycle-latency frame buffer model.
// Expected reads and rows are queued when a frame is started and popped by the monitor.
// Covers small frames, CIF, backpressure, zero size, busy pokes and mid-frame reset.
module tb_block_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        setup_frame;
  logic [11:0] width_in;
  logic [11:0] height_in;
  logic        start;
  logic        busy;
  logic        done;
  logic        spurious;
  logic        bp_mode;

  int chk_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [83:0] exp_q[$];
  logic [21:0] exp_rd[$];
  int outstanding = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic done_busy = 1'b0;
  int last_hs = 0;
  int first_rd = -1;
  int first_vld = -1;
  int start_edge = 0;
  logic hit = 1'b0;
  logic busy_seen = 1'b0;

  block_fetch_if #(.MEM_WIDTH(64)) bus ();

  block_fetch #(.MEM_WIDTH(64), .BLK(8), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .setup_frame (setup_frame),
    .width_in    (width_in),
    .height_in   (height_in),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] pix_word(input int x, input int y);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'((x + i) * 5 + y * 3 + (x ^ y));
    return w;
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {busy, done, bus.rd_en, bus.rd_x, bus.rd_y, bus.blk_valid}, '0);
    check({tag, "_blk"}, {bus.blk_data, bus.blk_row, bus.blk_bx, bus.blk_by, bus.blk_last}, '0);
  endtask

  // Frame buffer: word for (rd_x, rd_y) returned one cycle after rd_en.
  always @(posedge clk) begin
    bus.rd_valid <= bus.rd_en || spurious;
    bus.rd_data  <= pix_word(int'(bus.rd_x), int'(bus.rd_y));
  end

  // Downstream ready with 30% duty while backpressure is enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) bus.blk_ready = ($urandom_range(0, 99) < 30);
  end

  // Monitor: read order, credit limit, row scoreboard, done timing.
  always @(negedge clk) begin
    if (reset) begin
      if (busy) busy_seen = 1'b1;
      if (bus.rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        check("credit", outstanding < 2, 1'b1);
        if (exp_rd.size() == 0) check("rd_unexpected", bus.rd_en, 1'b0);
        else check("rd_xy", {bus.rd_x, bus.rd_y}, exp_rd.pop_front());
        if (bus.rd_x == 11'd24 && bus.rd_y == 11'd5) hit = 1'b1;
      end
      if (bus.blk_valid && first_vld < 0) first_vld = cyc;
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_q.size() == 0) check("row_unexpected", bus.blk_valid, 1'b0);
        else check("row_out", {bus.blk_data, bus.blk_row, bus.blk_bx, bus.blk_by, bus.blk_last},
                   exp_q.pop_front());
        outstanding--;
        last_hs = cyc;
      end
      if (bus.rd_en) outstanding++;
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
    end
  end

  task automatic setup(input int w, input int h);
    @(posedge clk); #1;
    setup_frame = 1'b1;
    width_in    = 12'(w);
    height_in   = 12'(h);
    @(posedge clk); #1;
    setup_frame = 1'b0;
  endtask

  task automatic load_expect(input int w, input int h);
    for (int by = 0; by < h / 8; by++)
      for (int bx = 0; bx < w / 8; bx++)
        for (int r = 0; r < 8; r++) begin
          exp_q.push_back({pix_word(bx * 8, by * 8 + r), 3'(r), 8'(bx), 8'(by),
                           (r == 7) && (bx == w / 8 - 1) && (by == h / 8 - 1)});
          exp_rd.push_back({11'(bx * 8), 11'(by * 8 + r)});
        end
  endtask

  // Setup, start, wait for done; start is sampled at edge start_edge.
  task automatic run_frame(input int w, input int h, input int budget, input string tag);
    int base_done;
    int n;
    setup(w, h);
    load_expect(w, h);
    first_rd  = -1;
    first_vld = -1;
    base_done = done_cnt;
    start      = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (done_cnt == base_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    check({tag, "_done"}, done_cnt - base_done, 1);
    check({tag, "_rows_left"}, exp_q.size(), 0);
    check({tag, "_reads_left"}, exp_rd.size(), 0);
    // First read during the cycle after the start edge; first row two cycles later.
    check({tag, "_first_rd"}, first_rd - start_edge, 0);
    check({tag, "_first_vld"}, first_vld - start_edge, 2);
    check({tag, "_done_after_hs"}, done_cyc - last_hs, 1);
    check({tag, "_busy_at_done"}, done_busy, 1'b0);
  endtask

  initial begin
    int base_done;
    int base_rd;
    reset       = 1'b0;
    setup_frame = 1'b0;
    width_in    = '0;
    height_in   = '0;
    start       = 1'b0;
    spurious    = 1'b0;
    bp_mode     = 1'b0;
    bus.blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    run_frame(16, 8, 200, "f16x8");
    run_frame(352, 288, 25000, "cif");

    bp_mode = 1'b1;
    run_frame(40, 24, 3000, "bp");
    bp_mode = 1'b0;
    @(posedge clk); #2;
    bus.blk_ready = 1'b1;

    // Zero-width frame: done next cycle, never busy, no reads.
    setup(0, 8);
    base_done = done_cnt;
    base_rd   = rd_cnt;
    busy_seen = 1'b0;
    start      = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("zero_done", done_cnt - base_done, 1);
    check("zero_done_cyc", done_cyc - start_edge, 0);
    check("zero_reads", rd_cnt - base_rd, 0);
    check("zero_busy", busy_seen, 1'b0);

    // start and setup_frame while busy are ignored; the 16x16 frame completes intact.
    fork
      run_frame(16, 16, 400, "f16x16");
      begin
        repeat (12) @(posedge clk);
        #1;
        check("poke_busy", busy, 1'b1);
        start = 1'b1;
        setup_frame = 1'b1;
        width_in  = 12'd8;
        height_in = 12'd8;
        @(posedge clk); #1;
        start = 1'b0;
        setup_frame = 1'b0;
      end
    join
    run_frame(8, 8, 200, "f8x8");

    // Reset during row 5 of block 3 of a 32x8 frame.
    setup(32, 8);
    load_expect(32, 8);
    hit = 1'b0;
    base_done = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      @(negedge clk);
      #2;
    end
    check("rst_hit", hit, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_rd.delete();
    outstanding = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    spurious = 1'b1;
    @(posedge clk); #1;
    spurious = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("spurious_dropped", bus.blk_valid, 1'b0);
    check("rst_no_done", done_cnt - base_done, 0);
    run_frame(32, 8, 300, "refetch");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
